instruction_fetch: RTL and testbench
====================================

// Module: instruction_fetch
// PURPOSE
//  Fetch stage directly downstream of the program counter. Takes the current PC, drives the
//  instruction-memory read port and returns {instruction, pc} pairs to the decoder over a
//  valid/ready handshake through a small output queue. Back-pressures the PC with pc_ready
//  so the PC advances only when a fetch is accepted. flush discards all queued and in-flight fetches.
// PARAMETERS
//  W      32  address/PC width (word addressed; the PC steps by 1 per instruction)
//  DW     32  instruction word width
//  DEPTH  2   output queue entries; power of 2, >= 2
// PORTS
//  clk          in   1   single clock, rising edge
//  clr          in   1   reset, asynchronous, active-high
//  pc           in   W   fetch address from the program counter
//  pc_valid     in   1   pc is a valid fetch request
//  pc_ready     out  1   fetch accepted this cycle; the PC may advance
//  imem_en      out  1   memory read strobe (= accept)
//  imem_addr    out  W   memory read address (= pc, combinational)
//  imem_rdata   in   DW  read data, valid exactly 1 cycle after imem_en
//  flush        in   1   redirect: drop everything, synchronous
//  instr        out  DW  instruction at the queue head
//  instr_pc     out  W   address of instr
//  instr_valid  out  1   queue head valid
//  instr_ready  in   1   decoder accepts the head
// BEHAVIOUR
//  Reset (clr high, async): queue empty, count=0, inflight=0, inflight_pc=0; instr_valid=0,
//   instr=0, instr_pc=0. pc_ready and imem_en are low while clr is high.
//  pop    = instr_valid & instr_ready.
//  accept = pc_valid & pc_ready.
//  pc_ready = !clr & !flush & ((count + inflight - pop) < DEPTH). Credit check: every
//   accepted fetch has a reserved slot, so the queue never overflows and a response is never dropped.
//  Issue (cycle N): imem_en=1, imem_addr=pc. inflight<=1 and inflight_pc<=pc; otherwise inflight<=0.
//  Return (cycle N+1): if inflight, push {imem_rdata, inflight_pc} into the queue at the clock edge.
//  Latency: accept in cycle N -> instr_valid in cycle N+2. With DEPTH>=2, the block sustains
//   1 instr/cycle when instr_ready is held high.
//  Simultaneous push and pop: both occur; count is unchanged. Push into a full queue with a
//   simultaneous pop is legal. Pop while empty cannot occur because instr_valid=0.
//  count width is clog2(DEPTH)+1. Read/write pointers wrap modulo DEPTH.
//  flush (cycle F): the queue is emptied at the F edge (count=0, ptrs=0) and inflight is cleared,
//   so a response arriving in F+1 is discarded. pc_ready=0 in F. A pop in F still completes
//   (the decoder owns squashing it). Acceptance resumes in F+1 with the redirected pc.
//  flush and clr together: clr dominates.
//  clr asserted mid-operation: all state drops at once. Any memory response after reset is ignored.
//  Output order is strictly the accept order. instr/instr_pc hold steady while
//   instr_valid & !instr_ready (no change until pop).
//  Queue outputs are driven from registered storage (head entry); no imem_rdata->instr comb path.
// STRUCTURE
//  Shared header cpu_defs.vh: ADDR_W=32, INSTR_W=32, FETCH_Q_DEPTH=2 defaults used by the
//   program counter, instruction memory and fetch stage.
//  Sub-module fetch_fifo #(WIDTH=DW+W, DEPTH): sync FIFO with push/pop/flush/count, async clr.
//   Top level holds the credit logic and the inflight register only.
// TESTING
//  1 Reset: clr=1 pulse mid-cycle -> all outputs 0 immediately, pc_ready=0 while clr=1.
//  2 Streaming: pc=0..7 with pc_valid=1, instr_ready=1, mem[a]=a+0x100 -> instr 0x100..0x107,
//    instr_pc 0..7; first instr_valid 2 cycles after the first accept; 1/cycle after that.
//  3 Back-pressure: instr_ready=0 from start, pc_valid=1 -> exactly 2 accepts (pc 0,1), then
//    pc_ready=0. Head holds pc 0 stable. Release ready -> pc 0,1 drain in order, fetch resumes at pc 2.
//  4 Full + pop: queue full, pop and pending push in the same cycle -> count stays 2, no loss.
//  5 Flush with an in-flight fetch: accept pc 5, flush next cycle -> pc 5 response never
//    appears. Queue is empty after the flush; pc 0x40 accepted in F+1 yields instr_pc 0x40.
//  6 Random valid/ready/flush for 10k cycles vs a scoreboard -> order kept,
//    no duplicates, no drops except those killed by a flush.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared fetch-stage defaults and small helpers.
//  ADDR_W        : PC / instruction-memory address width (word addressed)
//  INSTR_W       : instruction word width
//  FETCH_Q_DEPTH : output queue entries (power of 2, >= 2)
//  cnt_width()   : width of an occupancy counter that can hold 0..depth
package instruction_fetch_pkg;

  localparam int unsigned ADDR_W        = 32;
  localparam int unsigned INSTR_W       = 32;
  localparam int unsigned FETCH_Q_DEPTH = 2;

  // Occupancy counter width: one extra bit so that "full" (== depth) is representable.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/instruction_fetch_fifo.sv
// Synchronous FIFO holding fetched {instruction, pc} pairs.
// Ports:
//  clk, clr   : clock, asynchronous active-high reset
//  push_i     : write data_i at the clock edge
//  pop_i      : retire the head entry at the clock edge
//  flush_i    : empty the FIFO at the clock edge (dominates push/pop)
//  data_i     : entry to write
//  data_o     : head entry, driven straight from registered storage
//  valid_o    : FIFO not empty
//  count_o    : number of valid entries
module instruction_fetch_fifo
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         clr,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  input  logic [WIDTH-1:0]             data_i,
  output logic [WIDTH-1:0]             data_o,
  output logic                         valid_o,
  output logic [cnt_width(DEPTH)-1:0]  count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // Next-state for pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer/occupancy registers and entry storage.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_i && !flush_i) begin
        mem_q[wr_ptr_q] <= data_i;
      end
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign valid_o = (count_q != '0);
  assign count_o = count_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: takes the PC, reads instruction memory and queues {instr, pc} pairs for the decoder.
// Ports:
//  clk, clr            : clock, asynchronous active-high reset
//  pc, pc_valid        : fetch request from the program counter
//  pc_ready            : request accepted this cycle (PC may advance)
//  imem_en, imem_addr  : instruction-memory read strobe and address
//  imem_rdata          : read data, valid one cycle after imem_en
//  flush               : drop every queued and in-flight fetch
//  instr, instr_pc     : queue head instruction and its address
//  instr_valid/ready   : handshake towards the decoder
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned W     = ADDR_W,
  parameter int unsigned DW    = INSTR_W,
  parameter int unsigned DEPTH = FETCH_Q_DEPTH
) (
  input  logic          clk,
  input  logic          clr,
  input  logic [W-1:0]  pc,
  input  logic          pc_valid,
  output logic          pc_ready,
  output logic          imem_en,
  output logic [W-1:0]  imem_addr,
  input  logic [DW-1:0] imem_rdata,
  input  logic          flush,
  output logic [DW-1:0] instr,
  output logic [W-1:0]  instr_pc,
  output logic          instr_valid,
  input  logic          instr_ready
);

  localparam int unsigned CW = cnt_width(DEPTH);

  logic [CW-1:0]   count_s;
  logic [CW:0]     need_s;
  logic            pop_s;
  logic            accept_s;
  logic            ready_s;
  logic            valid_s;
  logic [DW+W-1:0] head_s;
  logic            inflight_q, inflight_d;
  logic [W-1:0]    inflight_pc_q, inflight_pc_d;

  assign pop_s = valid_s & instr_ready;

  // Credit check: a new fetch is issued only if queued + in-flight - leaving entries leave a free slot,
  // so every issued read is guaranteed room when its data returns.
  assign need_s   = {1'b0, count_s} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop_s};
  assign ready_s  = !clr && !flush && (need_s < (CW+1)'(DEPTH));
  assign accept_s = pc_valid & ready_s;

  // In-flight tracking: flush forces ready low, so no new fetch is marked in the flush cycle.
  always_comb begin
    inflight_d    = accept_s;
    inflight_pc_d = inflight_pc_q;
    if (accept_s) begin
      inflight_pc_d = pc;
    end else begin
      inflight_pc_d = inflight_pc_q;
    end
  end

  // In-flight register for the single outstanding memory read.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  instruction_fetch_fifo #(
    .WIDTH (DW + W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .clr     (clr),
    .push_i  (inflight_q),
    .pop_i   (pop_s),
    .flush_i (flush),
    .data_i  ({imem_rdata, inflight_pc_q}),
    .data_o  (head_s),
    .valid_o (valid_s),
    .count_o (count_s)
  );

  assign pc_ready    = ready_s;
  assign imem_en     = accept_s;
  assign imem_addr   = pc;
  assign instr       = head_s[DW+W-1:W];
  assign instr_pc    = head_s[W-1:0];
  assign instr_valid = valid_s;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

  logic        clk;
  logic        clr;
  logic [31:0] pc;
  logic        pc_valid;
  logic        pc_ready;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        flush;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;

  int checks   = 0;
  int failures = 0;

  logic [63:0] sb [$];
  int          cyc_n     = 0;
  int          pop_cnt   = 0;
  int          acc_cnt   = 0;
  int          last_pop_cyc = 0;
  logic [31:0] last_pop_pc  = 32'h0;
  bit          lat_arm   = 1'b0;
  int          first_acc = -1;
  int          first_val = -1;
  bit          auto_pc   = 1'b1;

  instruction_fetch dut (
    .clk         (clk),
    .clr         (clr),
    .pc          (pc),
    .pc_valid    (pc_valid),
    .pc_ready    (pc_ready),
    .imem_en     (imem_en),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .flush       (flush),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Instruction memory: mem[a] = a + 0x100, one-cycle read latency, garbage when not read.
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= imem_addr + 32'h100;
    else         imem_rdata <= $urandom();
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (clr) begin
      sb.delete();
    end else begin
      if (instr_valid && instr_ready) begin
        logic [63:0] e;
        pop_cnt++;
        last_pop_cyc = cyc_n;
        last_pop_pc  = instr_pc;
        chk("pop_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("pop_data", {instr, instr_pc}, e);
        end
      end
      if (flush) sb.delete();
      if (pc_valid && pc_ready) begin
        acc_cnt++;
        sb.push_back({pc + 32'h100, pc});
        if (lat_arm && first_acc < 0) first_acc = cyc_n;
      end
      if (lat_arm && instr_valid && first_val < 0) first_val = cyc_n;
    end
  end

  // One clock: observe accept on the falling edge, advance pc just after the rising edge.
  task automatic step();
    bit acc;
    @(negedge clk);
    acc = pc_valid && pc_ready;
    @(posedge clk);
    #1;
    if (acc && auto_pc) pc = pc + 32'd1;
  endtask

  initial begin
    int p0;
    int a0;
    clr = 1'b1; pc = 32'h0; pc_valid = 1'b1; flush = 1'b0; instr_ready = 1'b0;
    imem_rdata = 32'h0;
    #2;
    chk("rst_instr_valid", 64'(instr_valid), 64'd0);
    chk("rst_instr", 64'(instr), 64'd0);
    chk("rst_instr_pc", 64'(instr_pc), 64'd0);
    chk("rst_pc_ready", 64'(pc_ready), 64'd0);
    chk("rst_imem_en", 64'(imem_en), 64'd0);
    @(posedge clk); #1;
    clr = 1'b0; pc_valid = 1'b0;
    repeat (2) step();

    // Streaming pc 0..7
    lat_arm = 1'b1; first_acc = -1; first_val = -1;
    p0 = pop_cnt;
    pc = 32'h0; pc_valid = 1'b1; instr_ready = 1'b1;
    #1;
    chk("stream_imem_en", 64'(imem_en), 64'd1);
    chk("stream_imem_addr", 64'(imem_addr), 64'd0);
    for (int k = 0; k < 30 && pc != 32'd8; k++) step();
    pc_valid = 1'b0;
    repeat (5) step();
    lat_arm = 1'b0;
    chk("stream_latency", 64'(first_val - first_acc), 64'd2);
    chk("stream_pops", 64'(pop_cnt - p0), 64'd8);
    chk("stream_last_pc", 64'(last_pop_pc), 64'd7);
    chk("stream_rate", 64'(last_pop_cyc - first_val), 64'd7);

    // Back-pressure from pc 0
    pc = 32'h0; instr_ready = 1'b0; a0 = acc_cnt; pc_valid = 1'b1;
    repeat (3) step();
    repeat (4) begin
      step();
      chk("bp_head_valid", 64'(instr_valid), 64'd1);
      chk("bp_head_pc", 64'(instr_pc), 64'd0);
      chk("bp_head_instr", 64'(instr), 64'h100);
      chk("bp_pc_ready", 64'(pc_ready), 64'd0);
    end
    chk("bp_accepts", 64'(acc_cnt - a0), 64'd2);
    chk("bp_pc_held", 64'(pc), 64'd2);
    // Release: full queue pops while new fetches keep pushing.
    instr_ready = 1'b1;
    repeat (4) begin
      step();
      chk("full_pop_valid", 64'(instr_valid), 64'd1);
    end
    chk("bp_resume", 64'(pc >= 32'd5), 64'd1);
    pc_valid = 1'b0;
    repeat (5) step();
    chk("bp_drained", 64'(sb.size()), 64'd0);

    // Flush with an in-flight fetch of pc 5
    pc = 32'h5; pc_valid = 1'b1;
    step();
    pc_valid = 1'b0; flush = 1'b1;
    #1;
    chk("flush_pc_ready", 64'(pc_ready), 64'd0);
    step();
    flush = 1'b0;
    chk("flush_empty", 64'(instr_valid), 64'd0);
    p0 = pop_cnt;
    pc = 32'h40; pc_valid = 1'b1;
    step();
    pc_valid = 1'b0;
    repeat (5) step();
    chk("flush_pops", 64'(pop_cnt - p0), 64'd1);
    chk("flush_redirect_pc", 64'(last_pop_pc), 64'h40);

    // Asynchronous clear mid-operation
    pc = 32'h33; instr_ready = 1'b0; pc_valid = 1'b1;
    repeat (4) step();
    chk("pre_clr_head", 64'(instr_pc), 64'h33);
    #3;
    clr = 1'b1;
    #1;
    chk("clr_instr_valid", 64'(instr_valid), 64'd0);
    chk("clr_instr", 64'(instr), 64'd0);
    chk("clr_instr_pc", 64'(instr_pc), 64'd0);
    chk("clr_pc_ready", 64'(pc_ready), 64'd0);
    chk("clr_imem_en", 64'(imem_en), 64'd0);
    @(posedge clk); #1;
    chk("clr_hold_pc_ready", 64'(pc_ready), 64'd0);
    clr = 1'b0; pc_valid = 1'b0; instr_ready = 1'b1;
    repeat (3) step();
    chk("clr_after_empty", 64'(instr_valid), 64'd0);

    // Random valid/ready/flush against the scoreboard
    p0 = pop_cnt;
    pc = 32'h100;
    for (int k = 0; k < 10000; k++) begin
      step();
      pc_valid    = ($urandom_range(0, 3) != 0);
      instr_ready = ($urandom_range(0, 9) < 7);
      flush       = ($urandom_range(0, 31) == 0);
      if (flush) pc = $urandom() & 32'h0FFF_FFFF;
    end
    flush = 1'b0; pc_valid = 1'b0; instr_ready = 1'b1;
    repeat (6) step();
    chk("rand_drained", 64'(sb.size()), 64'd0);
    chk("rand_activity", 64'((pop_cnt - p0) > 1000), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
